// File: rtl/mi_nios_led_pio_pkg.sv
// Shared constants for the LED output PIO: register word addresses and STATUS bit layout.
package mi_nios_led_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK    = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam int unsigned STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/mi_nios_led_pio_if.sv
// Avalon-MM slave bus bundle for the LED PIO (select, write strobe, address, data).
interface mi_nios_led_pio_if;

  logic        chipselect;
  logic        write_n;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output chipselect,
    output write_n,
    output address,
    output writedata,
    input  readdata
  );

  modport slave (
    input  chipselect,
    input  write_n,
    input  address,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/mi_nios_led_blink_timer.sv
// Free-running blink timer: counts down from the period, toggling phase on each reload.
module mi_nios_led_blink_timer #(
  parameter int unsigned PERIOD_W     = 26,
  parameter int unsigned PERIOD_RESET = 24999999
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [PERIOD_W-1:0] load_value,
  output logic                phase
);

  logic [PERIOD_W-1:0] cnt_d, cnt_q;
  logic                phase_d, phase_q;

  // load_value doubles as the reload value; a PERIOD write outranks the countdown.
  always_comb begin
    cnt_d   = cnt_q - PERIOD_W'(1);
    phase_d = phase_q;
    if (load) begin
      cnt_d   = load_value;
      phase_d = 1'b1;
    end else if (cnt_q == '0) begin
      cnt_d   = load_value;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= PERIOD_W'(PERIOD_RESET);
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/mi_nios_led_pio.sv
// LED output PIO: DATA register with set/clear aliases, per-bit hardware blink, registered readback.
module mi_nios_led_pio
  import mi_nios_led_pio_pkg::*;
#(
  parameter int unsigned      WIDTH        = 8,
  parameter int unsigned      PERIOD_W     = 26,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int unsigned      PERIOD_RESET = 24999999
) (
  input  logic             clk,
  input  logic             reset,
  mi_nios_led_pio_if.slave bus,
  output logic [WIDTH-1:0] out_port
);

  logic                wr_en;
  logic [WIDTH-1:0]    wdata_w;
  logic [PERIOD_W-1:0] wdata_p;
  logic                period_load;
  logic                phase;

  logic [WIDTH-1:0]    data_d, data_q;
  logic [WIDTH-1:0]    blink_d, blink_q;
  logic [PERIOD_W-1:0] period_d, period_q;
  logic [31:0]         readdata_d, readdata_q;

  logic                unused_wdata;

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign wdata_w      = bus.writedata[WIDTH-1:0];
  assign wdata_p      = bus.writedata[PERIOD_W-1:0];
  assign unused_wdata = ^bus.writedata;

  always_comb begin
    data_d      = data_q;
    blink_d     = blink_q;
    period_d    = period_q;
    period_load = 1'b0;
    if (wr_en) begin
      case (bus.address)
        ADDR_DATA:     data_d  = wdata_w;
        ADDR_BLINK:    blink_d = wdata_w;
        ADDR_PERIOD: begin
          period_d    = wdata_p;
          period_load = 1'b1;
        end
        ADDR_OUTSET:   data_d  = data_q | wdata_w;
        ADDR_OUTCLEAR: data_d  = data_q & ~wdata_w;
        default: ;
      endcase
    end
  end

  // Readback mux sees pre-edge register values, so a same-cycle write returns the old value.
  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_DATA:   readdata_d[WIDTH-1:0]        = data_q;
      ADDR_BLINK:  readdata_d[WIDTH-1:0]        = blink_q;
      ADDR_PERIOD: readdata_d[PERIOD_W-1:0]     = period_q;
      ADDR_STATUS: readdata_d[STATUS_PHASE_BIT] = phase;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q     <= RESET_VALUE;
      blink_q    <= '0;
      period_q   <= PERIOD_W'(PERIOD_RESET);
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      blink_q    <= blink_d;
      period_q   <= period_d;
      readdata_q <= readdata_d;
    end
  end

  // period_d is the freshly written value on a PERIOD write and the held period otherwise.
  mi_nios_led_blink_timer #(
    .PERIOD_W     (PERIOD_W),
    .PERIOD_RESET (PERIOD_RESET)
  ) u_blink_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (period_load),
    .load_value (period_d),
    .phase      (phase)
  );

  assign bus.readdata = readdata_q;
  assign out_port     = data_q & (~blink_q | {WIDTH{phase}});

endmodule

// File: tb/tb_mi_nios_led_pio.sv
// Directed bench for mi_nios_led_pio; a second instance with a short reset period covers reset timing.
module tb_mi_nios_led_pio;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        cs    = 1'b0;
  logic        wn    = 1'b1;
  logic [2:0]  addr  = 3'd0;
  logic [31:0] wdata = 32'd0;
  logic [7:0]  out1, out2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mi_nios_led_pio_if bus1 ();
  mi_nios_led_pio_if bus2 ();

  assign bus1.chipselect = cs;
  assign bus1.write_n    = wn;
  assign bus1.address    = addr;
  assign bus1.writedata  = wdata;
  assign bus2.chipselect = cs;
  assign bus2.write_n    = wn;
  assign bus2.address    = addr;
  assign bus2.writedata  = wdata;

  mi_nios_led_pio #(
    .WIDTH        (8),
    .PERIOD_W     (26),
    .RESET_VALUE  (8'hA5),
    .PERIOD_RESET (24999999)
  ) dut1 (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus1),
    .out_port (out1)
  );

  mi_nios_led_pio #(
    .WIDTH        (8),
    .PERIOD_W     (26),
    .RESET_VALUE  (8'hA5),
    .PERIOD_RESET (20)
  ) dut2 (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus2),
    .out_port (out2)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [7:0]  exp_out;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    cs    = 1'b1;
    wn    = 1'b0;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    cs = 1'b0;
    wn = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a);
    addr = a;
    @(posedge clk);
    #1;
  endtask

  function automatic logic ph3(input int k);
    return ((k / 4) % 2) == 0;
  endfunction

  initial begin
    vecs[0]  = '{1'b1, 3'd0, 32'h0000_000F, 8'h0F, 32'h0};
    vecs[1]  = '{1'b1, 3'd4, 32'h0000_00F0, 8'hFF, 32'h0};
    vecs[2]  = '{1'b1, 3'd5, 32'h0000_003C, 8'hC3, 32'h0};
    vecs[3]  = '{1'b0, 3'd0, 32'h0,         8'hC3, 32'h0000_00C3};
    vecs[4]  = '{1'b1, 3'd6, 32'hFFFF_FFFF, 8'hC3, 32'h0};
    vecs[5]  = '{1'b0, 3'd6, 32'h0,         8'hC3, 32'h0};
    vecs[6]  = '{1'b0, 3'd4, 32'h0,         8'hC3, 32'h0};
    vecs[7]  = '{1'b0, 3'd5, 32'h0,         8'hC3, 32'h0};
    vecs[8]  = '{1'b0, 3'd1, 32'h0,         8'hC3, 32'h0};
    vecs[9]  = '{1'b0, 3'd2, 32'h0,         8'hC3, 32'd24999999};
    vecs[10] = '{1'b1, 3'd0, 32'hFFFF_FFAA, 8'hAA, 32'h0};
    vecs[11] = '{1'b0, 3'd0, 32'h0,         8'hAA, 32'h0000_00AA};
    vecs[12] = '{1'b0, 3'd7, 32'h0,         8'hAA, 32'h0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset out_port", {24'h0, out1}, 32'h0000_00A5);
    check("reset readdata", bus1.readdata, 32'h0);
    reset = 1'b0;
    bus_rd(3'd2);
    check("reset period", bus1.readdata, 32'd24999999);
    check("reset period dut2", bus2.readdata, 32'd20);
    bus_rd(3'd3);
    check("reset status", bus1.readdata, 32'd1);

    // Register writes, set/clear aliases, reserved and write-only addresses
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) begin
        bus_wr(vecs[i].addr, vecs[i].data);
      end else begin
        bus_rd(vecs[i].addr);
        check($sformatf("vec%0d readdata", i), bus1.readdata, vecs[i].exp_rd);
      end
      check($sformatf("vec%0d out_port", i), {24'h0, out1}, {24'h0, vecs[i].exp_out});
    end

    // Same-cycle write and read of DATA returns the old value
    cs    = 1'b1;
    wn    = 1'b0;
    addr  = 3'd0;
    wdata = 32'h55;
    @(posedge clk);
    #1;
    check("rw same cycle readdata", bus1.readdata, 32'hAA);
    check("rw same cycle out_port", {24'h0, out1}, 32'h55);
    cs = 1'b0;
    wn = 1'b1;
    @(posedge clk);
    #1;
    check("rw next readdata", bus1.readdata, 32'h55);

    // PERIOD=3 blink on bit 0
    bus_wr(3'd2, 32'd3);
    bus_wr(3'd1, 32'h01);
    bus_wr(3'd0, 32'h01);
    addr = 3'd3;
    for (int k = 3; k <= 14; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("blink3 out k=%0d", k), {24'h0, out1}, {31'h0, ph3(k)});
      check($sformatf("blink3 status k=%0d", k), bus1.readdata, {31'h0, ph3(k - 1)});
    end

    // PERIOD=0 toggles every cycle; a PERIOD rewrite forces phase high
    bus_wr(3'd2, 32'd0);
    bus_wr(3'd1, 32'hFF);
    bus_wr(3'd0, 32'hFF);
    for (int k = 3; k <= 8; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("blink0 out k=%0d", k), {24'h0, out1}, (k % 2 == 0) ? 32'hFF : 32'h00);
    end
    bus_wr(3'd2, 32'd0);
    check("period rewrite forces phase", {24'h0, out1}, 32'hFF);
    @(posedge clk);
    #1;
    check("toggle after rewrite", {24'h0, out1}, 32'h00);

    // Reset mid-count
    bus_wr(3'd2, 32'd100);
    addr = 3'd2;
    repeat (50) @(posedge clk);
    #1;
    check("mid-count out_port", {24'h0, out1}, 32'hFF);
    check("mid-count period", bus1.readdata, 32'd100);
    #3;
    reset = 1'b1;
    #1;
    check("async reset out_port", {24'h0, out1}, 32'hA5);
    check("async reset readdata", bus1.readdata, 32'h0);
    check("async reset out_port dut2", {24'h0, out2}, 32'hA5);
    repeat (2) @(posedge clk);
    #1;
    addr  = 3'd3;
    reset = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post-reset phase k=%0d", k), bus2.readdata, (k <= 21) ? 32'd1 : 32'd0);
    end
    check("post-reset phase dut1", bus1.readdata, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mi_nios_led_pio.md
Name: mi_nios_led_pio

Overview:
- Avalon-MM slave output PIO for the on-board LEDs: the write-direction counterpart of the switch input PIO on the Nios II system bus.
- Holds a CPU-writable output data register with atomic set/clear aliases.
- Adds a hardware blink generator, so selected bits toggle at a programmable rate without CPU involvement.
- Readback uses the same registered, 1-cycle read latency as the input PIO.

Parameters:
- WIDTH, 8, number of output bits (1..32).
- PERIOD_W, 26, width of the blink half-period register and counter.
- RESET_VALUE, 0, reset value of the DATA register (WIDTH bits).
- PERIOD_RESET, 24999999, reset half-period in clk cycles minus 1 (0.5 s at 50 MHz).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- address  input  3  word address.
- writedata  input  32  write data.
- readdata  output  32  registered read data, 1-cycle latency.
- out_port  output  WIDTH  LED drive.

Behaviour:
- Register map:
  - 0 DATA R/W.
  - 1 BLINK_EN R/W, one bit per output.
  - 2 PERIOD R/W, PERIOD_W bits.
  - 3 STATUS R: bit0 = phase, other bits 0.
  - 4 OUTSET W: DATA |= writedata.
  - 5 OUTCLEAR W: DATA &= ~writedata.
  - 6, 7 reserved: read 0, writes ignored.
- Width handling: writedata bits above WIDTH or PERIOD_W are ignored. Reads are zero-extended to 32 bits. OUTSET and OUTCLEAR read as 0.
- Reset (asynchronous, active-high): DATA=RESET_VALUE, BLINK_EN=0, PERIOD=PERIOD_RESET, cnt=PERIOD_RESET, phase=1, readdata=0. As a result out_port=RESET_VALUE.
- Reset asserted mid-count or mid-write aborts immediately. No write completes during reset.
- Writes: single cycle, no wait states. The register updates at the clock edge where the write is sampled.
- Readdata: on every clock, readdata <= zero-extended mux(address) of the register values before that edge. No read strobe is used. Consequence: a read in the same cycle as a write to the same register returns the old value.
- Blink timer (free-running):
  - cnt != 0: cnt decrements by 1.
  - cnt == 0: cnt reloads to PERIOD and phase toggles.
  - The phase therefore toggles every PERIOD+1 cycles. PERIOD=0 toggles every cycle.
  - A write to PERIOD loads PERIOD and cnt with the new value and forces phase=1 at that edge. This write takes priority over the timer's decrement/reload in the same cycle.
- Output: out_port[i] = DATA[i] & (~BLINK_EN[i] | phase). It is a combinational AND of registers only (glitch-free per bit) and changes after the edge that updates DATA, BLINK_EN or phase.
  - Blinking bits follow the phase only while DATA[i]=1.
  - Clearing BLINK_EN[i] returns bit i to steady DATA[i] on the next edge.
- Simultaneous-event rules:
  - OUTSET/OUTCLEAR are single-bus-cycle operations, so no same-cycle set/clear conflict can occur.
  - A write to DATA is never altered by the blink timer.

Decomposition:
- Shared package mi_nios_led_pio_pkg holds:
  - Address constants: ADDR_DATA=0, ADDR_BLINK=1, ADDR_PERIOD=2, ADDR_STATUS=3, ADDR_OUTSET=4, ADDR_OUTCLEAR=5.
  - STATUS_PHASE_BIT=0.
- One sub-module, mi_nios_led_blink_timer (inputs: clk, reset, load, load_value; outputs: phase). It owns cnt and phase.
- The top level contains the register file, the read mux and the output gating.

Test Plan:
1. Reset with RESET_VALUE=8'hA5 → out_port=8'hA5, readdata=0. Read address 2 → 24999999 on the next cycle. Read address 3 → 1.
2. Write DATA=8'h0F, then OUTSET 8'hF0, then OUTCLEAR 8'h3C → out_port steps 0F, FF, C3 on successive edges. Read address 0 returns C3 one cycle after presenting the address.
3. Write PERIOD=3, BLINK_EN=8'h01, DATA=8'h01 → out_port[0] toggles every 4 cycles. STATUS bit0 tracks out_port[0]. Bits 7:1 stay 0.
4. Write PERIOD=0 with BLINK_EN=8'hFF, DATA=8'hFF → out_port alternates FF/00 every cycle. Rewriting PERIOD forces phase=1 (out_port=FF) at that edge.
5. Same-cycle write DATA=8'h55 and read address 0 while DATA=8'hAA → readdata=AA. The next read returns 55. Writes to address 6 leave all registers unchanged; a read of address 6 returns 0.
6. Assert reset mid-count (PERIOD=100, cnt≈50, DATA=8'hFF) → outputs revert asynchronously to reset values before the next clk edge. After release, the first phase toggle occurs PERIOD_RESET+1 cycles later.
